// File: rtl/programmable_priority_pkg.sv
// rtl/programmable_priority_pkg.sv - shared types and helpers for the programmable priority encoder/decoder pair
// Contents: FSM state enum, pointer/index width helper, wrapping next-pointer helper.
package programmable_priority_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index/pointer width for a given number of requesters; never below 1 bit.
  function automatic int unsigned ptr_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Round-robin successor of idx; wraps at width-1, not at the next power of two.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned width);
    return (idx == width - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/priority_grant_decoder_if.sv
// rtl/priority_grant_decoder_if.sv - encoder/grantee to grant decoder bus
// Signals: enc_idx/enc_vld from the encoder, enc_pri back to it; dec_gnt/gnt_vld to the grantee,
// gnt_rdy/gnt_lock from it; dec_err pulse; gnt_tmo only with PRIORITY_GRANT_DECODER_TIMEOUT_EN.
// Modports: master = encoder/grantee side, slave = decoder side.
interface priority_grant_decoder_if #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned WIDTH_LOG = programmable_priority_pkg::ptr_width(WIDTH)
);

  logic [WIDTH_LOG-1:0] enc_idx;
  logic                 enc_vld;
  logic [WIDTH_LOG-1:0] enc_pri;
  logic [WIDTH-1:0]     dec_gnt;
  logic                 gnt_vld;
  logic                 gnt_rdy;
  logic                 gnt_lock;
  logic                 dec_err;
`ifdef PRIORITY_GRANT_DECODER_TIMEOUT_EN
  logic                 gnt_tmo;

  modport master (
    output enc_idx, enc_vld, gnt_rdy, gnt_lock,
    input  enc_pri, dec_gnt, gnt_vld, dec_err, gnt_tmo
  );

  modport slave (
    input  enc_idx, enc_vld, gnt_rdy, gnt_lock,
    output enc_pri, dec_gnt, gnt_vld, dec_err, gnt_tmo
  );
`else
  modport master (
    output enc_idx, enc_vld, gnt_rdy, gnt_lock,
    input  enc_pri, dec_gnt, gnt_vld, dec_err
  );

  modport slave (
    input  enc_idx, enc_vld, gnt_rdy, gnt_lock,
    output enc_pri, dec_gnt, gnt_vld, dec_err
  );
`endif

endinterface

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational index to one-hot decoder
// Ports: idx (index in), onehot (WIDTH lines out, all zero when idx >= WIDTH).
module onehot_decoder
  import programmable_priority_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned WIDTH_LOG = ptr_width(WIDTH)
) (
  input  logic [WIDTH_LOG-1:0] idx,
  output logic [WIDTH-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      onehot[i] = (32'(idx) == i);
    end
  end

endmodule

// File: rtl/priority_grant_decoder.sv
// rtl/priority_grant_decoder.sv - registered one-hot grant with release handshake and rotating priority pointer
// Ports: clk, rst (sync, active-high), bus (priority_grant_decoder_if.slave).
// Option: PRIORITY_GRANT_DECODER_TIMEOUT_EN adds a GRANT cycle counter, forced release and bus.gnt_tmo.
module priority_grant_decoder
  import programmable_priority_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  priority_grant_decoder_if.slave  bus
);

  localparam int unsigned WIDTH_LOG = ptr_width(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH_LOG-1:0] idx_q, idx_d;
  logic [WIDTH_LOG-1:0] pri_q, pri_d;
  logic [WIDTH-1:0]     gnt_q, gnt_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     onehot;
  logic                 idx_ok;
  logic                 release_ok;

  onehot_decoder #(.WIDTH(WIDTH)) u_onehot (
    .idx    (bus.enc_idx),
    .onehot (onehot)
  );

  // An out-of-range index decodes to all zeros, so "any bit set" doubles as the range check.
  assign idx_ok = |onehot;

`ifdef PRIORITY_GRANT_DECODER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo;

  // Forced release only counts when the grantee would not have released anyway.
  assign tmo         = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT - 1)) &&
                       !(bus.gnt_rdy && !bus.gnt_lock);
  assign release_ok  = (bus.gnt_rdy && !bus.gnt_lock) || tmo;
  assign bus.gnt_tmo = tmo;
`else
  assign release_ok  = bus.gnt_rdy && !bus.gnt_lock;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pri_d   = pri_q;
    gnt_d   = gnt_q;
    err_d   = 1'b0;
`ifdef PRIORITY_GRANT_DECODER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enc_vld) begin
          if (idx_ok) begin
            idx_d   = bus.enc_idx;
            gnt_d   = onehot;
            state_d = GRANT;
`ifdef PRIORITY_GRANT_DECODER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GRANT: begin
        // enc_vld/enc_idx are deliberately ignored here; the grant stays stable.
        if (release_ok) begin
          state_d = IDLE;
          gnt_d   = '0;
          pri_d   = WIDTH_LOG'(next_ptr(32'(idx_q), WIDTH));
        end else begin
`ifdef PRIORITY_GRANT_DECODER_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pri_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef PRIORITY_GRANT_DECODER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pri_q   <= pri_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
`ifdef PRIORITY_GRANT_DECODER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.enc_pri = pri_q;
  assign bus.dec_gnt = gnt_q;
  assign bus.gnt_vld = (state_q == GRANT);
  assign bus.dec_err = err_q;

  a_timeout_param: assert property (@(posedge clk) TIMEOUT >= 1);
  a_onehot0:       assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_vld_gnt:       assert property (@(posedge clk) disable iff (rst) (state_q == GRANT) == (gnt_q != '0));
  a_vld_state:     assert property (@(posedge clk) disable iff (rst) bus.gnt_vld == (state_q == GRANT));

endmodule

// File: doc/priority_grant_decoder.md
Name: priority_grant_decoder

Overview:
Consumer end of the programmable priority encoder interface. It takes the winning index and valid from the encoder and decodes them into a registered one-hot grant with a valid/ready release handshake. It owns the rotating priority pointer and drives it back to the encoder's enc_pri input. Together the two blocks form a round-robin arbiter.

Parameters:
WIDTH, 32, number of requesters/grant lines; any value >= 2, not required to be a power of two.
WIDTH_LOG, $clog2(WIDTH), localparam; index and pointer width.
TIMEOUT, 16, maximum GRANT cycles before forced release; used only with the optional feature; must be >= 1.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
enc_idx  input  WIDTH_LOG  winning index from the encoder.
enc_vld  input  1  enc_idx is valid; at least one request is pending.
enc_pri  output  WIDTH_LOG  priority pointer to the encoder; lowest index considered first.
dec_gnt  output  WIDTH  registered one-hot grant.
gnt_vld  output  1  dec_gnt is valid.
gnt_rdy  input  1  grantee accepts/completes; release condition.
gnt_lock  input  1  grantee holds the grant for multi-beat transfers; blocks release.
dec_err  output  1  one-cycle pulse: enc_vld with enc_idx >= WIDTH was dropped.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, enc_pri=0, dec_gnt=0, gnt_vld=0, dec_err=0. rst overrides every other input.
- Reset during GRANT: grant drops the cycle after the reset edge. No release pointer update occurs.
- FSM states: IDLE, GRANT.
- IDLE, enc_vld=1 and enc_idx<WIDTH:
  - Capture idx_q=enc_idx.
  - Next cycle: dec_gnt=1<<idx_q, gnt_vld=1, state=GRANT. Latency is 1 cycle from enc_vld to gnt_vld.
- IDLE, enc_vld=1 and enc_idx>=WIDTH (non-power-of-two WIDTH only):
  - No grant; dec_err=1 for one cycle; remain IDLE.
- IDLE, enc_vld=0: hold; gnt_vld=0, dec_gnt=0.
- GRANT:
  - dec_gnt and gnt_vld are stable; enc_vld and enc_idx are ignored.
  - Release when gnt_rdy=1 and gnt_lock=0.
  - gnt_rdy=1 with gnt_lock=1: no release; the grant holds.
- Release edge:
  - state=IDLE, gnt_vld=0, dec_gnt=0.
  - enc_pri = (idx_q==WIDTH-1) ? 0 : idx_q+1. Wrap is at WIDTH-1, not 2^WIDTH_LOG-1.
- enc_pri changes only on a release edge (or reset). It is stable through IDLE so the encoder output settles.
- Throughput: at most one grant per 2 cycles (GRANT, then at least one IDLE cycle). A back-to-back request in the release cycle is sampled in the following IDLE cycle against the updated enc_pri.
- Invariants, checked by assertions:
  - $onehot0(dec_gnt) always.
  - gnt_vld == (dec_gnt != 0).
  - gnt_vld == (state==GRANT).

Optional Feature:
Macro PRIORITY_GRANT_DECODER_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT+1) clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches TIMEOUT-1 without a release, release is forced at the next edge regardless of gnt_lock/gnt_rdy, with the normal pointer update.
  - Output port gnt_tmo (1 bit) pulses high in the forced-release cycle; reset value 0.
- Undefined: no counter and no gnt_tmo port; a grant holds indefinitely under gnt_lock.

Decomposition:
- Package programmable_priority_pkg:
  - FSM state enum (IDLE, GRANT).
  - Function for next pointer with wrap (idx, WIDTH).
  - Shared WIDTH_LOG computation usable by both the encoder and this decoder.
- Sub-module onehot_decoder (combinational; parameter WIDTH; input idx, output one-hot, all-zero when idx>=WIDTH). It is instantiated once, feeding the dec_gnt register; the encoder-side tests can reuse it.

Test Plan:
- rst=1 for 2 cycles, then rst=0, enc_vld=0 -> enc_pri=0, dec_gnt=0, gnt_vld=0, dec_err=0 every cycle.
- WIDTH=32, enc_vld=1, enc_idx=5 in IDLE; gnt_rdy=1 on the 3rd GRANT cycle:
  - dec_gnt=32'h0000_0020 and gnt_vld=1 one cycle later, held for 3 cycles.
  - After release: enc_pri=6, gnt_vld=0.
- WIDTH=32, grant idx=31, release -> enc_pri wraps to 0.
- WIDTH=6, grant idx=5, release -> enc_pri=0.
- WIDTH=6, enc_idx=7 with enc_vld=1 -> dec_err=1 for one cycle, no grant, enc_pri unchanged.
- Grant idx=3; gnt_lock=1, gnt_rdy=1 for 4 cycles -> grant held, enc_pri unchanged.
  - Then gnt_lock=0 -> release next edge, enc_pri=4.
  - Assert rst during a later GRANT -> gnt_vld=0, enc_pri=0 the cycle after.
- With PRIORITY_GRANT_DECODER_TIMEOUT_EN, TIMEOUT=4, grant idx=9, gnt_lock=1 held:
  - gnt_vld high exactly 4 cycles, gnt_tmo pulses once.
  - Afterwards enc_pri=10, state IDLE.
